// File: rtl/sub_bytes_serial.sv
// sub_bytes_serial: iterative AES-128 forward SubBytes, BYTES_PER_CYCLE S-box lookups per clock
module sub_bytes_serial #(
    parameter int BYTES_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);
    localparam int N  = 16 / BYTES_PER_CYCLE;
    localparam int CW = N > 1 ? $clog2(N) : 1;
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t        state, state_n;
    logic [127:0]  work, sub;
    logic [CW-1:0] k;
    logic          last;
    if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
        BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_param
        $error("sub_bytes_serial: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[2047 - 8*int'(x) -: 8];
    endfunction
    assign last      = k == CW'(N - 1);
    assign out_state = work;
    // Only the B bytes selected by the pass counter go through S-boxes this cycle
    always_comb begin
        sub = work;
        for (int i = 0; i < BYTES_PER_CYCLE; i++)
            sub[127 - 8*(int'(k)*BYTES_PER_CYCLE + i) -: 8] =
                sbox(work[127 - 8*(int'(k)*BYTES_PER_CYCLE + i) -: 8]);
    end
    always_comb begin
        in_ready  = state == IDLE && !reset;
        out_valid = state == DONE;
        busy      = state != IDLE;
        state_n   = state == IDLE ? (in_valid ? RUN : IDLE) :
                    state == RUN  ? (last ? DONE : RUN) :
                                    (out_ready ? IDLE : DONE);
    end
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            work <= '0;
            k    <= '0;
        end else if (state == IDLE && in_valid) begin
            work <= in_state;
            k    <= '0;
        end else if (state == RUN) begin
            work <= sub;
            if (!last) k <= k + 1'b1;
        end
    end
endmodule

// File: tb/tb_sub_bytes_serial.sv
// tb_sub_bytes_serial: directed vectors for all legal BYTES_PER_CYCLE, handshake, back-to-back and reset cases.
// The 256-byte sweep is checked against an S-box inverse derived from GF(2^8) arithmetic.
module tb_sub_bytes_serial;
    logic clk = 0, reset = 1;
    logic iv [5], ir [5], ov [5], orr [5], bz [5];
    logic [127:0] is [5], os [5];
    int tests = 0, fails = 0;

    localparam logic [127:0] APPB_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] APPB_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] BND_IN   = 128'h000153ff000153ff000153ff000153ff;
    localparam logic [127:0] BND_OUT  = 128'h637ced16637ced16637ced16637ced16;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        sub_bytes_serial #(.BYTES_PER_CYCLE(1 << g)) dut (
            .clk(clk), .reset(reset), .in_valid(iv[g]), .in_ready(ir[g]), .in_state(is[g]),
            .out_valid(ov[g]), .out_ready(orr[g]), .out_state(os[g]), .busy(bz[g])
        );
    end

    typedef struct {
        int           d;
        logic [127:0] din;
        logic [127:0] exp;
        int           lat;
    } vec_t;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction
    function automatic logic [7:0] rotl(input logic [7:0] s, input int n);
        return (s << n) | (s >> (8 - n));
    endfunction
    // Inverse S-box: inverse affine map, then multiplicative inverse x^254
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] t = rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05;
        logic [7:0] r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, t);
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ov(input int d, output int lat);
        lat = 0;
        while (!ov[d] && lat < 40) begin
            tick();
            lat++;
        end
        if (!ov[d]) begin
            fails++;
            $display("FAIL timeout_out_valid: dut %0d got no out_valid after %0d cycles", d, lat);
        end
    endtask

    task automatic release_out(input int d);
        orr[d] = 1;
        tick();
        orr[d] = 0;
    endtask

    // Present a block, return the result and cycles from accept edge to out_valid
    task automatic run_block(input int d, input logic [127:0] din, output logic [127:0] dout, output int lat);
        for (int i = 0; i < 40 && !ir[d]; i++) tick();
        is[d] = din;
        iv[d] = 1;
        tick();
        iv[d] = 0;
        wait_ov(d, lat);
        dout = os[d];
        release_out(d);
    endtask

    initial begin
        vec_t         vt [7];
        logic [127:0] got, inv, blk;
        int           lat, r1, r2, nhi;
        logic [127:0] s1, s2;
        for (int g = 0; g < 5; g++) begin
            iv[g] = 0; orr[g] = 0; is[g] = '0;
        end
        vt[0] = '{0, APPB_IN, APPB_OUT, 16};
        vt[1] = '{1, APPB_IN, APPB_OUT, 8};
        vt[2] = '{2, APPB_IN, APPB_OUT, 4};
        vt[3] = '{3, APPB_IN, APPB_OUT, 2};
        vt[4] = '{4, APPB_IN, APPB_OUT, 1};
        vt[5] = '{0, BND_IN, BND_OUT, 16};
        vt[6] = '{3, BND_IN, BND_OUT, 2};

        for (int i = 0; i < 3; i++) begin
            tick();
            chk("in_ready_during_reset", 128'(ir[0]), 128'(0));
        end
        reset = 0;
        tick();
        chk("in_ready_after_reset", 128'(ir[0]), 128'(1));
        chk("out_valid_after_reset", 128'(ov[0]), 128'(0));
        chk("busy_after_reset", 128'(bz[0]), 128'(0));
        chk("out_state_after_reset", os[0], 128'h0);

        for (int i = 0; i < 7; i++) begin
            run_block(vt[i].d, vt[i].din, got, lat);
            chk($sformatf("vec%0d_state", i), got, vt[i].exp);
            chk($sformatf("vec%0d_latency", i), 128'(lat), 128'(vt[i].lat));
        end

        for (int b = 0; b < 16; b++) begin
            for (int j = 0; j < 16; j++) blk[127 - 8*j -: 8] = 8'(b*16 + j);
            run_block(0, blk, got, lat);
            for (int j = 0; j < 16; j++) inv[127 - 8*j -: 8] = inv_sbox(got[127 - 8*j -: 8]);
            chk($sformatf("sweep_blk%0d", b), inv, blk);
        end

        // Output stall, in_valid during RUN/DONE ignored, accept right after handshake
        is[0] = APPB_IN;
        iv[0] = 1;
        tick();
        is[0] = BND_IN;
        wait_ov(0, lat);
        chk("stall_latency", 128'(lat), 128'(16));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_state", os[0], APPB_OUT);
            chk("stall_in_ready", 128'(ir[0]), 128'(0));
        end
        orr[0] = 1;
        tick();
        orr[0] = 0;
        chk("hs_out_valid_drop", 128'(ov[0]), 128'(0));
        chk("hs_in_ready_rise", 128'(ir[0]), 128'(1));
        tick();
        iv[0] = 0;
        chk("hs_second_accepted", 128'(bz[0]), 128'(1));
        wait_ov(0, lat);
        chk("hs_second_latency", 128'(lat), 128'(16));
        chk("hs_second_state", os[0], BND_OUT);
        release_out(0);

        // Back-to-back with out_ready tied high
        orr[0] = 1;
        is[0] = APPB_IN;
        iv[0] = 1;
        r1 = -1; r2 = -1; nhi = 0; s1 = '0; s2 = '0;
        tick();
        is[0] = BND_IN;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (c == 18) iv[0] = 0;
            if (ov[0]) begin
                nhi++;
                if (r1 < 0) begin r1 = c; s1 = os[0]; end
                else if (r2 < 0) begin r2 = c; s2 = os[0]; end
            end
        end
        orr[0] = 0;
        chk("b2b_first_rise", 128'(r1), 128'(16));
        chk("b2b_spacing", 128'(r2 - r1), 128'(18));
        chk("b2b_high_cycles", 128'(nhi), 128'(2));
        chk("b2b_first_state", s1, APPB_OUT);
        chk("b2b_second_state", s2, BND_OUT);

        // Reset while pass 7 is in progress
        is[0] = APPB_IN;
        iv[0] = 1;
        tick();
        iv[0] = 0;
        for (int c = 1; c <= 7; c++) tick();
        chk("pre_reset_busy", 128'(bz[0]), 128'(1));
        reset = 1;
        #1;
        chk("in_ready_in_reset", 128'(ir[0]), 128'(0));
        tick();
        chk("rst_out_valid", 128'(ov[0]), 128'(0));
        chk("rst_busy", 128'(bz[0]), 128'(0));
        chk("rst_out_state", os[0], 128'h0);
        reset = 0;
        tick();
        chk("rst_in_ready", 128'(ir[0]), 128'(1));
        run_block(0, BND_IN, got, lat);
        chk("rst_fresh_state", got, BND_OUT);
        chk("rst_fresh_latency", 128'(lat), 128'(16));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
